l2spm_rr_arbiter: RTL and testbench



---
 rtl/l2spm_rr_arbiter_if.sv | 48 ++++
 rtl/l2spm_rr_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_l2spm_rr_arbiter.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/l2spm_rr_arbiter_if.sv
// Requester and memory-side bundle of the L2 scratchpad arbiter.
// stall_cnt_o exists only when L2SPM_ARB_STALL_CNT_EN is defined.
interface l2spm_rr_arbiter_if #(
    parameter int NumReq    = 7,
    parameter int AddrWidth = 32,
    parameter int DataWidth = 64
);
    logic [NumReq-1:0]                    req_i;
    logic [NumReq-1:0][AddrWidth-1:0]     addr_i;
    logic [NumReq-1:0]                    we_i;
    logic [NumReq-1:0][DataWidth/8-1:0]   be_i;
    logic [NumReq-1:0][DataWidth-1:0]     wdata_i;
    logic [NumReq-1:0]                    gnt_o;
    logic [NumReq-1:0]                    rvalid_o;
    logic                                 rerr_o;
    logic [DataWidth-1:0]                 rdata_o;
    logic                                 mem_req_o;
    logic [AddrWidth-1:0]                 mem_addr_o;
    logic                                 mem_we_o;
    logic [DataWidth/8-1:0]               mem_be_o;
    logic [DataWidth-1:0]                 mem_wdata_o;
    logic                                 mem_gnt_i;
    logic                                 mem_rvalid_i;
    logic [DataWidth-1:0]                 mem_rdata_i;
`ifdef L2SPM_ARB_STALL_CNT_EN
    logic [NumReq-1:0][31:0]              stall_cnt_o;
`endif

    modport slave (
`ifdef L2SPM_ARB_STALL_CNT_EN
        output stall_cnt_o,
`endif
        input  req_i, addr_i, we_i, be_i, wdata_i,
        output gnt_o, rvalid_o, rerr_o, rdata_o,
        output mem_req_o, mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o,
        input  mem_gnt_i, mem_rvalid_i, mem_rdata_i
    );

    modport master (
`ifdef L2SPM_ARB_STALL_CNT_EN
        input  stall_cnt_o,
`endif
        output req_i, addr_i, we_i, be_i, wdata_i,
        input  gnt_o, rvalid_o, rerr_o, rdata_o,
        input  mem_req_o, mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o,
        output mem_gnt_i, mem_rvalid_i, mem_rdata_i
    );
endinterface

// File: rtl/l2spm_rr_arbiter.sv
// Round-robin arbiter sharing the L2 scratchpad port; in-order response routing
// via an ID FIFO. Define L2SPM_ARB_STALL_CNT_EN to add per-requester stall counters.
module l2spm_rr_arbiter_chk #(
    parameter int NumReq = 7
) (
    input logic              clk,
    input logic              rst,
    input logic              mem_rvalid,
    input logic              fifo_empty,
    input logic              head_err,
    input logic [NumReq-1:0] gnt,
    input logic [NumReq-1:0] rvalid
);
    a_no_stray_rvalid: assert property (@(posedge clk) disable iff (rst)
        !(mem_rvalid && (fifo_empty || head_err)));
    a_gnt_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(gnt));
    a_rvalid_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(rvalid));
endmodule

module l2spm_rr_arbiter #(
    parameter int                   NumReq         = 7,
    parameter int                   AddrWidth      = 32,
    parameter int                   DataWidth      = 64,
    parameter logic [AddrWidth-1:0] BaseAddr       = 32'h1C00_0000,
    parameter logic [AddrWidth-1:0] WinLength      = 32'h0008_0000,
    parameter int                   MaxOutstanding = 4
) (
    input logic               clk_i,
    input logic               rst_i,
    l2spm_rr_arbiter_if.slave bus
);
    localparam int IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;
    localparam int PtrW = $clog2(MaxOutstanding);
    localparam logic [AddrWidth:0] WinLo = {1'b0, BaseAddr};
    localparam logic [AddrWidth:0] WinHi = {1'b0, BaseAddr} + {1'b0, WinLength};
    localparam logic [PtrW:0] PtrInc = {{PtrW{1'b0}}, 1'b1};

    typedef struct packed {
        logic [IdxW-1:0] id;
        logic            err;
    } ord_entry_t;

    // One extra bit keeps the window end from wrapping for windows touching the top.
    function automatic logic in_window(input logic [AddrWidth-1:0] addr);
        logic [AddrWidth:0] a;
        a = {1'b0, addr};
        return (a >= WinLo) && (a < WinHi);
    endfunction

    function automatic logic [IdxW-1:0] rr_index(input logic [IdxW-1:0] base,
                                                 input int unsigned off);
        int unsigned sum;
        sum = (32'(base) + off) % unsigned'(NumReq);
        return IdxW'(sum);
    endfunction

    logic [IdxW-1:0] rr_ptr_r;
    ord_entry_t      fifo_r [MaxOutstanding];
    logic [PtrW:0]   wr_ptr_r;
    logic [PtrW:0]   rd_ptr_r;

    logic            win_valid_s;
    logic [IdxW-1:0] win_idx_s;
    logic [IdxW-1:0] cand_s;
    logic            hit_s;
    logic            win_in_s;
    logic            grant_ok_s;
    logic            fifo_full_s;
    logic            fifo_empty_s;
    logic            push_s;
    logic            pop_s;
    ord_entry_t      head_s;

    assign fifo_empty_s = (wr_ptr_r == rd_ptr_r);
    assign fifo_full_s  = (wr_ptr_r[PtrW] != rd_ptr_r[PtrW]) &&
                          (wr_ptr_r[PtrW-1:0] == rd_ptr_r[PtrW-1:0]);
    assign head_s       = fifo_r[rd_ptr_r[PtrW-1:0]];
    assign win_in_s     = in_window(bus.addr_i[win_idx_s]);
    assign grant_ok_s   = win_valid_s && !fifo_full_s && !rst_i;

    // Round-robin search; scanning downwards lets the closest requester to the pointer win.
    always_comb begin
        win_valid_s = 1'b0;
        win_idx_s   = '0;
        cand_s      = '0;
        hit_s       = 1'b0;
        for (int k = NumReq - 1; k >= 0; k--) begin
            cand_s      = rr_index(rr_ptr_r, unsigned'(k));
            hit_s       = bus.req_i[cand_s];
            win_idx_s   = hit_s ? cand_s : win_idx_s;
            win_valid_s = win_valid_s | hit_s;
        end
    end

    // Request path: forward in-window winners, self-grant out-of-window ones.
    always_comb begin
        bus.gnt_o       = '0;
        bus.mem_req_o   = 1'b0;
        bus.mem_addr_o  = '0;
        bus.mem_we_o    = 1'b0;
        bus.mem_be_o    = '0;
        bus.mem_wdata_o = '0;
        push_s          = 1'b0;
        if (grant_ok_s) begin
            if (win_in_s) begin
                bus.mem_req_o            = 1'b1;
                bus.mem_addr_o           = bus.addr_i[win_idx_s] - BaseAddr;
                bus.mem_we_o             = bus.we_i[win_idx_s];
                bus.mem_be_o             = bus.be_i[win_idx_s];
                bus.mem_wdata_o          = bus.wdata_i[win_idx_s];
                bus.gnt_o[win_idx_s]     = bus.mem_gnt_i;
                push_s                   = bus.mem_gnt_i;
            end else begin
                bus.gnt_o[win_idx_s]     = 1'b1;
                push_s                   = 1'b1;
            end
        end else begin
            push_s = 1'b0;
        end
    end

    // Response path: error entries retire on their own, others wait for the memory.
    always_comb begin
        bus.rvalid_o = '0;
        bus.rerr_o   = 1'b0;
        bus.rdata_o  = '0;
        pop_s        = 1'b0;
        if (!fifo_empty_s && !rst_i) begin
            if (head_s.err) begin
                bus.rvalid_o[head_s.id] = 1'b1;
                bus.rerr_o              = 1'b1;
                pop_s                   = 1'b1;
            end else begin
                bus.rvalid_o[head_s.id] = bus.mem_rvalid_i;
                bus.rdata_o             = bus.mem_rdata_i & {DataWidth{bus.mem_rvalid_i}};
                pop_s                   = bus.mem_rvalid_i;
            end
        end else begin
            pop_s = 1'b0;
        end
    end

    // Order FIFO and round-robin pointer.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_ptr_r <= '0;
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            for (int i = 0; i < MaxOutstanding; i++) begin
                fifo_r[i] <= '0;
            end
        end else begin
            if (push_s) begin
                fifo_r[wr_ptr_r[PtrW-1:0]] <= '{id: win_idx_s, err: ~win_in_s};
                wr_ptr_r                   <= wr_ptr_r + PtrInc;
                rr_ptr_r                   <= rr_index(win_idx_s, 32'd1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PtrInc;
            end
        end
    end

`ifdef L2SPM_ARB_STALL_CNT_EN
    logic [NumReq-1:0][31:0] stall_cnt_r;

    // Saturating count of cycles each requester waits without a grant.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt_r <= '0;
        end else begin
            for (int i = 0; i < NumReq; i++) begin
                if (bus.req_i[i] && !bus.gnt_o[i] && (stall_cnt_r[i] != 32'hFFFF_FFFF)) begin
                    stall_cnt_r[i] <= stall_cnt_r[i] + 32'd1;
                end
            end
        end
    end

    assign bus.stall_cnt_o = stall_cnt_r;
`endif

    l2spm_rr_arbiter_chk #(.NumReq(NumReq)) u_chk (
        .clk        (clk_i),
        .rst        (rst_i),
        .mem_rvalid (bus.mem_rvalid_i),
        .fifo_empty (fifo_empty_s),
        .head_err   (head_s.err),
        .gnt        (bus.gnt_o),
        .rvalid     (bus.rvalid_o)
    );
endmodule

// File: tb/tb_l2spm_rr_arbiter.sv
// Directed bench for l2spm_rr_arbiter with hand-computed expectations.
module tb_l2spm_rr_arbiter;
    localparam int NumReq = 7;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    int   total = 0;
    int   bad   = 0;
    logic [63:0] e;

    l2spm_rr_arbiter_if bus ();

    l2spm_rr_arbiter dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic idle();
        bus.req_i        = '0;
        bus.addr_i       = '0;
        bus.we_i         = '0;
        bus.be_i         = '0;
        bus.wdata_i      = '0;
        bus.mem_gnt_i    = 1'b0;
        bus.mem_rvalid_i = 1'b0;
        bus.mem_rdata_i  = '0;
    endtask

    task automatic set_req(input int i, input logic [31:0] a);
        bus.req_i[i]   = 1'b1;
        bus.addr_i[i]  = a;
        bus.we_i[i]    = i[0];
        bus.be_i[i]    = 8'(8'h01 << i);
        bus.wdata_i[i] = 64'hA0 + 64'(i);
    endtask

    initial begin
        idle();
        // Reset: outputs quiet even with live requests
        for (int i = 0; i < NumReq; i++) set_req(i, 32'h1C00_0100 + 32'(i) * 32'd8);
        bus.mem_gnt_i = 1'b1;
        tick();
        #1;
        chk("rst_gnt", 64'(bus.gnt_o), 64'd0);
        chk("rst_mem_req", 64'(bus.mem_req_o), 64'd0);
        chk("rst_mem_addr", 64'(bus.mem_addr_o), 64'd0);
        chk("rst_rvalid", 64'(bus.rvalid_o), 64'd0);
        chk("rst_rerr", 64'(bus.rerr_o), 64'd0);
        chk("rst_rdata", bus.rdata_o, 64'd0);
        rst_i = 1'b0;

        // All requesters, memory always ready, response one cycle after each grant
        for (int k = 0; k <= 7; k++) begin
            if (k > 0) begin
                bus.mem_rvalid_i = 1'b1;
                bus.mem_rdata_i  = 64'hD000 + 64'(k);
            end
            #1;
            e = 64'd1 << (k % 7);
            chk("rr_gnt", 64'(bus.gnt_o), e);
            chk("rr_mem_addr", 64'(bus.mem_addr_o), 64'h100 + 64'((k % 7) * 8));
            chk("rr_mem_we", 64'(bus.mem_we_o), 64'((k % 7) & 1));
            chk("rr_mem_be", 64'(bus.mem_be_o), 64'd1 << (k % 7));
            chk("rr_mem_wdata", bus.mem_wdata_o, 64'hA0 + 64'(k % 7));
            if (k > 0) begin
                chk("rr_rvalid", 64'(bus.rvalid_o), 64'd1 << ((k - 1) % 7));
                chk("rr_rdata", bus.rdata_o, 64'hD000 + 64'(k));
            end else begin
                chk("rr_rvalid_first", 64'(bus.rvalid_o), 64'd0);
            end
            tick();
        end
        bus.req_i        = '0;
        bus.mem_rdata_i  = 64'hD008;
        #1;
        chk("rr_last_rvalid", 64'(bus.rvalid_o), 64'h01);
        chk("rr_last_rdata", bus.rdata_o, 64'hD008);
        tick();
        idle();

        // One past the window end: self-granted, error response next cycle
        set_req(3, 32'h1C08_0000);
        bus.mem_rdata_i = 64'hDEAD;
        #1;
        chk("oor_gnt", 64'(bus.gnt_o), 64'h08);
        chk("oor_mem_req", 64'(bus.mem_req_o), 64'd0);
        chk("oor_mem_addr", 64'(bus.mem_addr_o), 64'd0);
        chk("oor_mem_wdata", bus.mem_wdata_o, 64'd0);
        tick();
        bus.req_i = '0;
        #1;
        chk("oor_rvalid", 64'(bus.rvalid_o), 64'h08);
        chk("oor_rerr", 64'(bus.rerr_o), 64'd1);
        chk("oor_rdata", bus.rdata_o, 64'd0);
        tick();
        #1;
        chk("oor_rvalid_gone", 64'(bus.rvalid_o), 64'd0);

        // Last doubleword inside the window
        set_req(0, 32'h1C07_FFF8);
        bus.mem_gnt_i = 1'b1;
        #1;
        chk("top_gnt", 64'(bus.gnt_o), 64'h01);
        chk("top_mem_req", 64'(bus.mem_req_o), 64'd1);
        chk("top_mem_addr", 64'(bus.mem_addr_o), 64'h0007_FFF8);
        tick();
        bus.req_i        = '0;
        bus.mem_rvalid_i = 1'b1;
        bus.mem_rdata_i  = 64'h1234;
        #1;
        chk("top_rvalid", 64'(bus.rvalid_o), 64'h01);
        chk("top_rerr", 64'(bus.rerr_o), 64'd0);
        chk("top_rdata", bus.rdata_o, 64'h1234);
        tick();
        bus.mem_rvalid_i = 1'b0;

        // Just below the window base
        set_req(2, 32'h1BFF_FFFC);
        #1;
        chk("low_gnt", 64'(bus.gnt_o), 64'h04);
        chk("low_mem_req", 64'(bus.mem_req_o), 64'd0);
        tick();
        bus.req_i = '0;
        #1;
        chk("low_rvalid", 64'(bus.rvalid_o), 64'h04);
        chk("low_rerr", 64'(bus.rerr_o), 64'd1);
        tick();

        // Fill the order FIFO, then a same-cycle pop must not free a slot
        set_req(5, 32'h1C00_0200);
        for (int n = 0; n < 4; n++) begin
            #1;
            chk("full_fill_gnt", 64'(bus.gnt_o), 64'h20);
            tick();
        end
        #1;
        chk("full_block_gnt", 64'(bus.gnt_o), 64'd0);
        chk("full_block_mem_req", 64'(bus.mem_req_o), 64'd0);
        tick();
        bus.mem_rvalid_i = 1'b1;
        bus.mem_rdata_i  = 64'h55;
        #1;
        chk("full_pop_gnt", 64'(bus.gnt_o), 64'd0);
        chk("full_pop_rvalid", 64'(bus.rvalid_o), 64'h20);
        tick();
        bus.mem_rvalid_i = 1'b0;
        #1;
        chk("full_resume_gnt", 64'(bus.gnt_o), 64'h20);
        tick();
        bus.req_i = '0;
        for (int n = 0; n < 4; n++) begin
            bus.mem_rvalid_i = 1'b1;
            #1;
            chk("full_drain_rvalid", 64'(bus.rvalid_o), 64'h20);
            tick();
        end
        bus.mem_rvalid_i = 1'b0;
        #1;
        chk("full_empty_rvalid", 64'(bus.rvalid_o), 64'd0);

        // Error response queued behind two in-window reads
        set_req(1, 32'h1C00_0300);
        #1;
        chk("ord_gnt_a", 64'(bus.gnt_o), 64'h02);
        tick();
        #1;
        chk("ord_gnt_b", 64'(bus.gnt_o), 64'h02);
        tick();
        bus.req_i[1] = 1'b0;
        set_req(4, 32'h2000_0000);
        #1;
        chk("ord_gnt_err", 64'(bus.gnt_o), 64'h10);
        chk("ord_rvalid_wait0", 64'(bus.rvalid_o), 64'd0);
        tick();
        bus.req_i = '0;
        #1;
        chk("ord_rvalid_wait1", 64'(bus.rvalid_o), 64'd0);
        tick();
        bus.mem_rvalid_i = 1'b1;
        bus.mem_rdata_i  = 64'hB1;
        #1;
        chk("ord_rvalid_a", 64'(bus.rvalid_o), 64'h02);
        chk("ord_rdata_a", bus.rdata_o, 64'hB1);
        chk("ord_rerr_a", 64'(bus.rerr_o), 64'd0);
        tick();
        bus.mem_rdata_i = 64'hB2;
        #1;
        chk("ord_rvalid_b", 64'(bus.rvalid_o), 64'h02);
        chk("ord_rdata_b", bus.rdata_o, 64'hB2);
        tick();
        bus.mem_rvalid_i = 1'b0;
        #1;
        chk("ord_rvalid_err", 64'(bus.rvalid_o), 64'h10);
        chk("ord_rerr", 64'(bus.rerr_o), 64'd1);
        chk("ord_rdata_err", bus.rdata_o, 64'd0);
        tick();
        #1;
        chk("ord_done", 64'(bus.rvalid_o), 64'd0);

        // Reset with a transaction in flight clears FIFO and pointer
        set_req(2, 32'h1C00_0400);
        #1;
        chk("mid_gnt", 64'(bus.gnt_o), 64'h04);
        tick();
        idle();
        rst_i = 1'b1;
        set_req(1, 32'h1C00_0500);
        set_req(4, 32'h1C00_0600);
        bus.mem_gnt_i = 1'b1;
        #1;
        chk("mid_rst_gnt", 64'(bus.gnt_o), 64'd0);
        chk("mid_rst_mem_req", 64'(bus.mem_req_o), 64'd0);
        tick();
        rst_i = 1'b0;
        #1;
        chk("mid_after_gnt", 64'(bus.gnt_o), 64'h02);
        chk("mid_after_rvalid", 64'(bus.rvalid_o), 64'd0);
        tick();
        bus.req_i        = '0;
        bus.mem_rvalid_i = 1'b1;
        bus.mem_rdata_i  = 64'hC1;
        #1;
        chk("mid_after_resp", 64'(bus.rvalid_o), 64'h02);
        tick();
        idle();

`ifdef L2SPM_ARB_STALL_CNT_EN
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        #1;
        chk("stall_rst1", 64'(bus.stall_cnt_o[1]), 64'd0);
        chk("stall_rst4", 64'(bus.stall_cnt_o[4]), 64'd0);
        set_req(1, 32'h1C00_0700);
        for (int n = 0; n < 5; n++) tick();
        #1;
        chk("stall_cnt1", 64'(bus.stall_cnt_o[1]), 64'd5);
        chk("stall_cnt0", 64'(bus.stall_cnt_o[0]), 64'd0);
        chk("stall_gnt", 64'(bus.gnt_o), 64'd0);
        rst_i         = 1'b1;
        bus.mem_gnt_i = 1'b1;
        tick();
        #1;
        chk("stall_clr", 64'(bus.stall_cnt_o[1]), 64'd0);
        chk("stall_clr_gnt", 64'(bus.gnt_o), 64'd0);
        chk("stall_clr_rvalid", 64'(bus.rvalid_o), 64'd0);
        rst_i = 1'b0;
        idle();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
